magic_nor_sequencer: RTL
========================

# magic_nor_sequencer

Cycle-accurate controller that evaluates a MAGIC NOR-only netlist on an emulated memristor row. An 8-input NOR netlist such as the rd84 weight functions is loaded once as a program of two-input NOR operations. For each input vector, the block runs the MAGIC INIT/EVAL sequence over a small cell array and returns the selected output cell. It sits between the synthesized NOR netlists and the crossbar model, providing the reference sequencing and latency for mapping studies.

## Interface
- `N_IN`, 8, number of primary inputs; they are loaded into cells `0..N_IN-1`.
- `N_CELLS`, 32, number of cells in the row; `CW = $clog2(N_CELLS)`.
- `PROG_DEPTH`, 32, program memory depth; `PW = $clog2(PROG_DEPTH)`.
- `clk` in 1: single clock. Reset is synchronous and active-high (see `rst`).
- `rst` in 1: synchronous, active-high reset.
- `prog_we` in 1: program word write strobe.
- `prog_addr` in PW: program word address.
- `prog_wdata` in 3*CW: `{dst, src_a, src_b}`.
- `cfg_we` in 1: writes `prog_len` and `out_cell`.
- `cfg_len` in PW+1: number of ops; legal range `0..PROG_DEPTH`.
- `cfg_out` in CW: output cell index.
- `prog_err` out 1: one-cycle pulse when `prog_we` or `cfg_we` is asserted outside IDLE.
- `in_valid`, `in_ready` in/out 1: input vector handshake.
- `in_data` in N_IN: input vector.
- `out_valid`, `out_ready` out/in 1: result handshake.
- `out_data` out 1: value of `cells[out_cell]`.
- `busy` out 1: high in INIT or EVAL.

## Operation
- States:
  - IDLE: `in_ready = (prog_len != 0)`. Program and config writes are accepted only here.
  - On an `in_valid`/`in_ready` handshake: `cells[i] <= in_data[i]` for `i < N_IN`; other cells are unchanged; `pc <= 0`; go to INIT.
  - INIT: `cells[dst(pc)] <= 1`, modelling the MAGIC output-memristor initialization. Go to EVAL.
  - EVAL: `cells[dst] <= ~(cells[src_a] | cells[src_b])`. Sources are read after INIT, so `src == dst` reads 1 and yields 0.
    - If `pc == prog_len-1`, go to DONE; otherwise `pc++` and go to INIT.
  - DONE: `out_valid = 1`, `out_data = cells[out_cell]`, held stable until `out_ready`. On the handshake, go to IDLE.
- NOT is encoded as NOR with `src_a == src_b`. There is no other opcode.
- `dst < N_IN` is legal and overwrites the input cell for later ops.
- Program write and config write in the same cycle are both applied.
- A `cfg_len` value greater than `PROG_DEPTH` saturates to `PROG_DEPTH`.
- Any write outside IDLE is dropped and pulses `prog_err`; the running evaluation is unaffected.
- `in_valid` is ignored while the block is not in IDLE; there is no input buffering.

## Timing
- Reset values:
  - state = IDLE; `in_ready = 0` (because `prog_len = 0`); `out_valid = 0`; `out_data = 0`; `busy = 0`; `prog_err = 0`.
  - `pc = 0`; `prog_len = 0`; `out_cell = 0`; all cells = 0.
  - Program memory is not reset.
- Latency from input handshake to the first `out_valid` cycle is `2*prog_len + 1` cycles.
  - Example: 21 ops gives 43 cycles.
- Throughput is one vector per `2*prog_len + 2` cycles when `out_ready` is held at 1.
- `out_data` is registered, so it is valid in the first cycle `out_valid` is high.
- Reset asserted mid-run returns to IDLE on the next edge and discards the current result.

## Structure
- `magic_pkg`: `state_t` enum (IDLE, INIT, EVAL, DONE), `nor_op_t` packed struct `{dst, src_a, src_b}`, and `CW`/`PW` derivation functions.
- Sub-module `magic_cell_array`:
  - `N_CELLS` flops.
  - Two combinational read ports.
  - One write port with `wr_init` (force to 1) and `wr_eval` (write NOR of the read ports).
  - Bulk-load port for the inputs.
- Top level holds the program memory (flops), the FSM, `pc` and the config registers.

## Test plan
- **rd84f3 program, all ones.** Load the 21-op NOR program for the 8-input AND netlist, `out_cell = 28`. Input `in_data = 8'hFF` → `out_data = 1` exactly 43 cycles after the handshake.
- **rd84f3 program, one bit low.** Same program, `in_data = 8'hFE` and `8'h7F` → `out_data = 0`. With `out_ready` held at 1, vectors are accepted every 44 cycles.
- **Empty program.**
  - `prog_len = 0` → `in_ready` stays 0.
  - `cfg_len = 40` → `prog_len` reads as 32.
- **`src == dst` op.** Single op `{dst=9, a=9, b=0}` with `in_data[0] = 0` → `cells[9] = 0`, `out_data = 0`.
- **Write during busy.** Assert `prog_we` while in EVAL → `prog_err` pulses for one cycle and the result equals the golden model.
- **Backpressure and reset.**
  - `out_ready = 0` for 10 cycles → `out_data` stable and `in_ready = 0`.
  - `rst` asserted mid-run → IDLE next cycle, `out_valid = 0`, `prog_len = 0`.

Source files
------------

// File: rtl/magic_pkg.sv
// Shared types for the MAGIC NOR sequencer: FSM states, the NOR op word layout
// and the width helpers used to size cell and program addresses.
package magic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cw_of(input int n_cells);
    return $clog2(n_cells);
  endfunction

  function automatic int pw_of(input int prog_depth);
    return $clog2(prog_depth);
  endfunction

  localparam int DEF_N_CELLS    = 32;
  localparam int DEF_PROG_DEPTH = 32;
  localparam int DEF_CW         = cw_of(DEF_N_CELLS);
  localparam int DEF_PW         = pw_of(DEF_PROG_DEPTH);

  // One program word: dst cell is MAGIC-initialised, then written with NOR(src_a, src_b).
  typedef struct packed {
    logic [DEF_CW-1:0] dst;
    logic [DEF_CW-1:0] src_a;
    logic [DEF_CW-1:0] src_b;
  } nor_op_t;

endpackage

// File: rtl/magic_cell_array.sv
// Emulated memristor row: one bit per cell, bulk input load, two combinational
// read ports and a single write port that either initialises to 1 or stores a NOR.
module magic_cell_array #(
  parameter int N_IN    = 8,
  parameter int N_CELLS = 32,
  parameter int CW      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [N_IN-1:0]    load_data,
  input  logic [CW-1:0]      rd_a_addr,
  input  logic [CW-1:0]      rd_b_addr,
  output logic               rd_a_data,
  output logic               rd_b_data,
  input  logic [CW-1:0]      wr_addr,
  input  logic               wr_init,
  input  logic               wr_eval,
  output logic [N_CELLS-1:0] cells_q
);

  logic [N_CELLS-1:0] cells;

  assign rd_a_data = cells[rd_a_addr];
  assign rd_b_data = cells[rd_b_addr];
  assign cells_q   = cells;

  always_ff @(posedge clk) begin
    if (rst) begin
      cells <= '0;
    end else if (load_en) begin
      cells[N_IN-1:0] <= load_data;
    end else if (wr_init) begin
      cells[wr_addr] <= 1'b1;
    end else if (wr_eval) begin
      cells[wr_addr] <= ~(rd_a_data | rd_b_data);
    end
  end

endmodule

// File: rtl/magic_nor_sequencer.sv
// Runs a loaded NOR-only program over the cell array once per input vector,
// issuing a MAGIC INIT cycle followed by an EVAL cycle for every op.
module magic_nor_sequencer
  import magic_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int N_CELLS    = DEF_N_CELLS,
  parameter int PROG_DEPTH = DEF_PROG_DEPTH,
  localparam int CW        = cw_of(N_CELLS),
  localparam int PW        = pw_of(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_we,
  input  logic [PW-1:0]   prog_addr,
  input  logic [3*CW-1:0] prog_wdata,
  input  logic            cfg_we,
  input  logic [PW:0]     cfg_len,
  input  logic [CW-1:0]   cfg_out,
  output logic            prog_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic            busy,
  output logic [1:0]      dbg_state,
  output logic [PW:0]     dbg_prog_len
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; out_valid/out_data stay stable until that edge, and in_valid is only
  // looked at while in_ready is high (IDLE with a non-empty program).

  localparam logic [PW:0] LEN_MAX = (PW+1)'(PROG_DEPTH);

  logic [3*CW-1:0]    prog_mem [PROG_DEPTH];
  state_t             state, state_nxt;
  logic [PW-1:0]      pc;
  logic [PW:0]        prog_len;
  logic [CW-1:0]      out_cell;
  logic               out_q;
  nor_op_t            cur_op;
  logic               idle, load_en, last_op, wr_init, wr_eval;
  logic               rd_a, rd_b;
  logic [N_CELLS-1:0] cells;

  assign idle      = (state == IDLE);
  assign cur_op    = prog_mem[pc];
  assign last_op   = ({1'b0, pc} == (prog_len - 1'b1));
  assign in_ready  = idle && (prog_len != '0);
  assign load_en   = in_valid && in_ready;
  assign prog_err  = (prog_we || cfg_we) && !idle;
  assign out_data  = out_q;
  assign dbg_state = state;
  assign dbg_prog_len = prog_len;

  always_comb begin
    state_nxt = state;
    wr_init   = 1'b0;
    wr_eval   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (load_en) state_nxt = INIT;
      INIT: begin
        wr_init   = 1'b1;
        busy      = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        wr_eval   = 1'b1;
        busy      = 1'b1;
        state_nxt = last_op ? DONE : INIT;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      prog_len <= '0;
      out_cell <= '0;
      out_q    <= 1'b0;
    end else begin
      if (idle && cfg_we) begin
        prog_len <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        out_cell <= cfg_out;
      end
      if (load_en) pc <= '0;
      else if (wr_eval && !last_op) pc <= pc + 1'b1;
      // The final EVAL may itself write the output cell, so forward the NOR result.
      if (wr_eval && last_op)
        out_q <= (cur_op.dst == out_cell) ? ~(rd_a | rd_b) : cells[out_cell];
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && idle) prog_mem[prog_addr] <= prog_wdata;
  end

  magic_cell_array #(
    .N_IN    (N_IN),
    .N_CELLS (N_CELLS),
    .CW      (CW)
  ) u_cells (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_data (in_data),
    .rd_a_addr (cur_op.src_a),
    .rd_b_addr (cur_op.src_b),
    .rd_a_data (rd_a),
    .rd_b_data (rd_b),
    .wr_addr   (cur_op.dst),
    .wr_init   (wr_init),
    .wr_eval   (wr_eval),
    .cells_q   (cells)
  );

endmodule
